// File: rtl/lsb_pkg.sv
// lsb_pkg: op / mem_len encodings and decode helpers for the load/store queue.
// Optional misalignment trap in lsb_queue is enabled by defining LSB_MISALIGN_EN.
package lsb_pkg;

  localparam logic [2:0] LSB_OP_LB  = 3'd0;
  localparam logic [2:0] LSB_OP_LH  = 3'd1;
  localparam logic [2:0] LSB_OP_LW  = 3'd2;
  localparam logic [2:0] LSB_OP_LBU = 3'd3;
  localparam logic [2:0] LSB_OP_LHU = 3'd4;
  localparam logic [2:0] LSB_OP_SB  = 3'd5;
  localparam logic [2:0] LSB_OP_SH  = 3'd6;
  localparam logic [2:0] LSB_OP_SW  = 3'd7;

  typedef enum logic [1:0] {
    LSB_SZ_B = 2'd0,
    LSB_SZ_H = 2'd1,
    LSB_SZ_W = 2'd2
  } lsb_size_e;

  localparam logic LSB_LEN_SEXT = 1'b1;
  localparam logic LSB_LEN_ZEXT = 1'b0;

  function automatic logic is_store(input logic [2:0] op);
    return op >= LSB_OP_SB;
  endfunction

  function automatic logic [2:0] op_to_len(input logic [2:0] op);
    logic [2:0] len;
    len = 3'b000;
    unique case (op)
      LSB_OP_LB:  len = {LSB_LEN_SEXT, LSB_SZ_B};
      LSB_OP_LH:  len = {LSB_LEN_SEXT, LSB_SZ_H};
      LSB_OP_LW:  len = {LSB_LEN_SEXT, LSB_SZ_W};
      LSB_OP_LBU: len = {LSB_LEN_ZEXT, LSB_SZ_B};
      LSB_OP_LHU: len = {LSB_LEN_ZEXT, LSB_SZ_H};
      LSB_OP_SB:  len = {LSB_LEN_ZEXT, LSB_SZ_B};
      LSB_OP_SH:  len = {LSB_LEN_ZEXT, LSB_SZ_H};
      LSB_OP_SW:  len = {LSB_LEN_ZEXT, LSB_SZ_W};
      default:    len = 3'b000;
    endcase
    return len;
  endfunction

  function automatic logic is_misaligned(
    input logic [2:0] len,
    input logic [1:0] a
  );
    logic mis;
    mis = 1'b0;
    unique case (lsb_size_e'(len[1:0]))
      LSB_SZ_H: mis = a[0];
      LSB_SZ_W: mis = a != 2'b00;
      default:  mis = 1'b0;
    endcase
    return mis;
  endfunction

endpackage

// File: rtl/lsb_wakeup.sv
// lsb_wakeup: CDB tag matcher; the lowest-numbered matching port
// supplies the value.
module lsb_wakeup
  import lsb_pkg::*;
#(
  parameter int TAG_BITS  = 4,
  parameter int CDB_PORTS = 2
) (
  input  logic [CDB_PORTS-1:0]          cdb_valid_i,
  input  logic [CDB_PORTS*TAG_BITS-1:0] cdb_tag_i,
  input  logic [CDB_PORTS*32-1:0]       cdb_value_i,
  input  logic [TAG_BITS-1:0]           tag_i,
  output logic                          hit_o,
  output logic [31:0]                   value_o
);

  always_comb begin
    hit_o   = 1'b0;
    value_o = '0;
    // walk high to low so port 0 is written last and wins
    for (int p = CDB_PORTS - 1; p >= 0; p--) begin
      if (cdb_valid_i[p] &&
          cdb_tag_i[p*TAG_BITS +: TAG_BITS] == tag_i) begin
        hit_o   = 1'b1;
        value_o = cdb_value_i[p*32 +: 32];
      end
    end
  end

endmodule

// File: rtl/lsb_queue.sv
// lsb_queue: in-order load/store queue with store commit tracking.
// Define LSB_MISALIGN_EN to trap misaligned heads and expose res_exc.
module lsb_queue
  import lsb_pkg::*;
#(
  parameter int DEPTH     = 16,
  parameter int TAG_BITS  = 4,
  parameter int CDB_PORTS = 2
) (
  input  logic                          clk_in,
  input  logic                          rst_in,
  input  logic                          rdy_in,
  input  logic                          flush_in,
  input  logic                          iss_valid,
  output logic                          iss_ready,
  input  logic [2:0]                    iss_op,
  input  logic [TAG_BITS-1:0]           iss_tag,
  input  logic [31:0]                   iss_imm,
  input  logic                          iss_j_rdy,
  input  logic [31:0]                   iss_j_val,
  input  logic [TAG_BITS-1:0]           iss_j_tag,
  input  logic                          iss_k_rdy,
  input  logic [31:0]                   iss_k_val,
  input  logic [TAG_BITS-1:0]           iss_k_tag,
  input  logic [CDB_PORTS-1:0]          cdb_valid,
  input  logic [CDB_PORTS*TAG_BITS-1:0] cdb_tag,
  input  logic [CDB_PORTS*32-1:0]       cdb_value,
  input  logic                          commit_valid,
  input  logic [TAG_BITS-1:0]           commit_tag,
  output logic                          mem_req,
  output logic                          mem_wr,
  output logic [2:0]                    mem_len,
  output logic [31:0]                   mem_addr,
  output logic [31:0]                   mem_wdata,
  input  logic                          mem_ack,
  input  logic [31:0]                   mem_rdata,
  output logic                          res_valid,
  output logic [TAG_BITS-1:0]           res_tag,
  output logic [31:0]                   res_value,
`ifdef LSB_MISALIGN_EN
  output logic                          res_exc,
`endif
  output logic                          full,
  output logic                          empty
);

  localparam int AW = $clog2(DEPTH);
  localparam int CW = AW + 1;

  logic [DEPTH-1:0]    busy_q, rdj_q, rdk_q, com_q, kill_q;
  logic [2:0]          op_q  [DEPTH];
  logic [TAG_BITS-1:0] tag_q [DEPTH];
  logic [TAG_BITS-1:0] qj_q  [DEPTH];
  logic [TAG_BITS-1:0] qk_q  [DEPTH];
  logic [31:0]         imm_q [DEPTH];
  logic [31:0]         vj_q  [DEPTH];
  logic [31:0]         vk_q  [DEPTH];

  logic [AW-1:0] head_q, head_d, tail_q, tail_d;
  logic [CW-1:0] cnt_q, cnt_d, ccnt_q, ccnt_d, keep_n;

  logic        ij_hit, ik_hit;
  logic [31:0] ij_cdb, ik_cdb;

  lsb_wakeup #(.TAG_BITS(TAG_BITS), .CDB_PORTS(CDB_PORTS)) u_iss_j (
    .cdb_valid_i (cdb_valid),
    .cdb_tag_i   (cdb_tag),
    .cdb_value_i (cdb_value),
    .tag_i       (iss_j_tag),
    .hit_o       (ij_hit),
    .value_o     (ij_cdb)
  );

  lsb_wakeup #(.TAG_BITS(TAG_BITS), .CDB_PORTS(CDB_PORTS)) u_iss_k (
    .cdb_valid_i (cdb_valid),
    .cdb_tag_i   (cdb_tag),
    .cdb_value_i (cdb_value),
    .tag_i       (iss_k_tag),
    .hit_o       (ik_hit),
    .value_o     (ik_cdb)
  );

  logic [DEPTH-1:0] wj_hit, wk_hit;
  logic [31:0]      wj_val [DEPTH];
  logic [31:0]      wk_val [DEPTH];

  for (genvar g = 0; g < DEPTH; g++) begin : g_wake
    lsb_wakeup #(.TAG_BITS(TAG_BITS), .CDB_PORTS(CDB_PORTS)) u_j (
      .cdb_valid_i (cdb_valid),
      .cdb_tag_i   (cdb_tag),
      .cdb_value_i (cdb_value),
      .tag_i       (qj_q[g]),
      .hit_o       (wj_hit[g]),
      .value_o     (wj_val[g])
    );
    lsb_wakeup #(.TAG_BITS(TAG_BITS), .CDB_PORTS(CDB_PORTS)) u_k (
      .cdb_valid_i (cdb_valid),
      .cdb_tag_i   (cdb_tag),
      .cdb_value_i (cdb_value),
      .tag_i       (qk_q[g]),
      .hit_o       (wk_hit[g]),
      .value_o     (wk_val[g])
    );
  end

  logic [2:0]  h_op;
  logic        h_busy, h_st, h_go, h_mis;
  logic [31:0] h_addr;

  assign h_op   = op_q[head_q];
  assign h_busy = busy_q[head_q];
  assign h_st   = is_store(h_op);
  assign h_addr = vj_q[head_q] + imm_q[head_q];
  assign h_go   = h_busy && rdj_q[head_q] && rdk_q[head_q] &&
                  (!h_st || com_q[head_q]);

`ifdef LSB_MISALIGN_EN
  assign h_mis = is_misaligned(op_to_len(h_op), h_addr[1:0]);
`else
  assign h_mis = 1'b0;
`endif

  assign mem_req   = h_go && !h_mis;
  assign mem_wr    = h_st;
  assign mem_len   = op_to_len(h_op);
  assign mem_addr  = h_addr;
  assign mem_wdata = vk_q[head_q];

  logic             do_iss, do_ret, do_fl, do_kill, com_any;
  logic [DEPTH-1:0] com_set, keep;

  assign full      = cnt_q == CW'(DEPTH);
  assign empty     = cnt_q == '0;
  assign iss_ready = !full && !flush_in;
  assign do_iss    = rdy_in && iss_valid && iss_ready;
  assign do_ret    = rdy_in && h_go && (h_mis || mem_ack);
  assign do_fl     = rdy_in && flush_in;
  assign do_kill   = do_fl && !do_ret && mem_req && !h_st;

  assign res_valid = do_ret && !h_st && !kill_q[head_q] && !flush_in;
  assign res_tag   = tag_q[head_q];
  assign res_value = h_mis ? 32'd0 : mem_rdata;
`ifdef LSB_MISALIGN_EN
  assign res_exc   = res_valid && h_mis;
`endif

  always_comb begin
    com_set = '0;
    for (int i = 0; i < DEPTH; i++) begin
      com_set[i] = rdy_in && commit_valid && busy_q[i] &&
                   is_store(op_q[i]) && !com_q[i] &&
                   tag_q[i] == commit_tag;
    end
  end

  assign com_any = |com_set;

  // flush keeps either the killed in-flight load or the committed-store prefix
  always_comb begin
    head_d = head_q + AW'(do_ret);
    ccnt_d = ccnt_q + CW'(com_any) - CW'(do_ret && h_st);
    keep_n = do_kill ? CW'(1) : ccnt_d;
    if (do_fl) begin
      tail_d = head_d + keep_n[AW-1:0];
      cnt_d  = keep_n;
    end else begin
      tail_d = tail_q + AW'(do_iss);
      cnt_d  = cnt_q + CW'(do_iss) - CW'(do_ret);
    end
    keep = '0;
    for (int i = 0; i < DEPTH; i++) begin
      keep[i] = {1'b0, AW'(i) - head_d} < keep_n;
    end
  end

  always_ff @(posedge clk_in or negedge rst_in) begin
    if (!rst_in) begin
      head_q <= '0;
      tail_q <= '0;
      cnt_q  <= '0;
      ccnt_q <= '0;
      busy_q <= '0;
      rdj_q  <= '0;
      rdk_q  <= '0;
      com_q  <= '0;
      kill_q <= '0;
      for (int i = 0; i < DEPTH; i++) begin
        op_q[i]  <= '0;
        tag_q[i] <= '0;
        qj_q[i]  <= '0;
        qk_q[i]  <= '0;
        imm_q[i] <= '0;
        vj_q[i]  <= '0;
        vk_q[i]  <= '0;
      end
    end else if (rdy_in) begin
      head_q <= head_d;
      tail_q <= tail_d;
      cnt_q  <= cnt_d;
      ccnt_q <= ccnt_d;
      for (int i = 0; i < DEPTH; i++) begin
        if (busy_q[i] && !rdj_q[i] && wj_hit[i]) begin
          rdj_q[i] <= 1'b1;
          vj_q[i]  <= wj_val[i];
        end
        if (busy_q[i] && !rdk_q[i] && wk_hit[i]) begin
          rdk_q[i] <= 1'b1;
          vk_q[i]  <= wk_val[i];
        end
        if (com_set[i]) com_q[i] <= 1'b1;
      end
      if (do_ret) begin
        busy_q[head_q] <= 1'b0;
        com_q[head_q]  <= 1'b0;
        kill_q[head_q] <= 1'b0;
      end
      if (do_kill) kill_q[head_q] <= 1'b1;
      if (do_iss) begin
        busy_q[tail_q] <= 1'b1;
        op_q[tail_q]   <= iss_op;
        tag_q[tail_q]  <= iss_tag;
        imm_q[tail_q]  <= iss_imm;
        com_q[tail_q]  <= 1'b0;
        kill_q[tail_q] <= 1'b0;
        rdj_q[tail_q]  <= iss_j_rdy || ij_hit;
        vj_q[tail_q]   <= iss_j_rdy ? iss_j_val : ij_cdb;
        qj_q[tail_q]   <= iss_j_tag;
        rdk_q[tail_q]  <= !is_store(iss_op) || iss_k_rdy || ik_hit;
        vk_q[tail_q]   <= iss_k_rdy ? iss_k_val : ik_cdb;
        qk_q[tail_q]   <= iss_k_tag;
      end
      if (do_fl) begin
        for (int i = 0; i < DEPTH; i++) begin
          if (!keep[i]) begin
            busy_q[i] <= 1'b0;
            com_q[i]  <= 1'b0;
            kill_q[i] <= 1'b0;
          end
        end
      end
    end
  end

endmodule

// File: doc/lsb_queue.md
# lsb_queue

Parametrised in-order load/store queue between the issue stage, the reorder buffer (RoB) and the data-memory controller. It generalises the LSB to configurable depth, RoB tag width and number of CDB wakeup ports. It also adds explicit store commit, so that committed stores survive a misprediction flush and still drain to memory. Loads and stores go to memory strictly in program order, one at a time, from the queue head.

## Interface
- DEPTH, 16: entries; power of two, ≥2
- TAG_BITS, 4: RoB tag width
- CDB_PORTS, 2: number of result broadcast ports snooped
- clk_in  in  1  clock, rising edge
- rst_in  in  1  reset, asynchronous, active-low
- rdy_in  in  1  global enable; when low, all state holds (async reset still acts)
- flush_in  in  1  mispredict clear from RoB
- iss_valid  in  1  issue request
- iss_ready  out  1  = !full && !flush_in
- iss_op  in  3  0 LB, 1 LH, 2 LW, 3 LBU, 4 LHU, 5 SB, 6 SH, 7 SW
- iss_tag  in  TAG_BITS  destination RoB id
- iss_imm  in  32  address offset
- iss_j_rdy / iss_j_val / iss_j_tag  in  1/32/TAG_BITS  base operand: ready flag, value, producer tag
- iss_k_rdy / iss_k_val / iss_k_tag  in  1/32/TAG_BITS  store data operand; ignored for loads
- cdb_valid  in  CDB_PORTS  broadcast valid per port
- cdb_tag  in  CDB_PORTS*TAG_BITS  packed tags, port 0 in the LSBs
- cdb_value  in  CDB_PORTS*32  packed values
- commit_valid / commit_tag  in  1/TAG_BITS  RoB retires the store with this tag
- mem_req  out  1  request valid; held stable until mem_ack
- mem_wr  out  1  1 = store
- mem_len  out  3  [1:0] size (0 byte, 1 half, 2 word); [2] sign-extend for loads, 0 for stores
- mem_addr / mem_wdata  out  32/32  vj+imm, vk
- mem_ack / mem_rdata  in  1/32  completion pulse; read data already extended
- res_valid / res_tag / res_value  out  1/TAG_BITS/32  load result to the RoB/CDB
- full / empty  out  1/1  occupancy flags

## Operation
- Per entry: busy, op, tag, imm, vj/qj/rdj, vk/qk/rdk, committed, killed.
- State: head, tail (log2 DEPTH bits, natural wrap), count (log2 DEPTH+1 bits), commit_cnt.
- Issue (iss_valid && iss_ready):
  - write the entry at tail; tail++ and count++.
  - Per operand, first match wins: rdy flag set → take the value; else CDB hit this cycle (lowest port wins) → take the CDB value; else record the tag and wait.
  - Loads set rdk=1 at issue.
- Wakeup: every busy entry with !rd and a matching cdb_valid/tag captures the value. Lowest port wins.
- Commit: a busy store whose tag matches sets committed; commit_cnt++.
- Head dispatch: mem_req is high when the head is busy, rdj && rdk, and either (load) or (store && committed). A killed head keeps mem_req high.
- mem_ack: head retires; head++, count-- (commit_cnt-- for a store). res_valid = mem_ack && head is a load && !killed, driven combinationally in the same cycle.
- Flush, with commit applied before flush:
  - If the head is a load with mem_req high: mark it killed; tail = head+1.
  - Otherwise: tail = head + commit_cnt.
  - All other entries are cleared. Issue is ignored that cycle.
- flush and mem_ack in the same cycle: the ack retires the head and its result is suppressed; the new tail equals head_next + commit_cnt_next.
- Committed stores always form a contiguous prefix from head. No store is committed behind an unfinished load.

## Timing
- Reset values: mem_req 0, res_valid 0, full 0, empty 1, iss_ready 1; all pointers and counters 0; every entry not busy.
- Issue to mem_req: ≥1 cycle (registered entry, combinational head decode).
- Load result latency: the mem_ack cycle (0 extra).
- full = count==DEPTH. Issue and retire in the same cycle with full=1 is refused (iss_ready low).
- Simultaneous issue, ack and wakeup in one cycle are all applied; count changes by issue − retire.
- Reset asserted mid-transaction drops the in-flight request immediately; the memory controller is reset by the same signal.

## Configuration
- LSB_MISALIGN_EN:
  - Defined: a head with addr misaligned for its size (half: addr[0]; word: addr[1:0]≠0) does not raise mem_req. It retires in one cycle with res_valid=1, res_value=0, plus an extra output res_exc=1.
  - For a misaligned store, retirement occurs once it is committed and raises no res_valid.
  - Undefined: no check and no res_exc port; misaligned addresses are passed through unchanged.

## Structure
- Package lsb_pkg:
  - op encoding constants (LSB_OP_LB … LSB_OP_SW)
  - mem_len encoding
  - function op_to_len
  - function is_store
- Sub-module lsb_wakeup: a combinational CDB tag matcher; CDB_PORTS-wide priority mux returning hit and value. It is instantiated once per operand at issue and once per operand per entry.

## Test plan
- Issue LW tag 3, j_rdy=1 val 0x100, imm 4 → next cycle mem_req=1, mem_addr=0x104, mem_len=3'b110; ack with rdata 0xDEAD → res_valid=1, res_tag=3, res_value=0xDEAD same cycle.
- Issue SW tag 5 with j waiting on tag 2; CDB port 1 broadcasts tag 2 val 0x200 → mem_req stays 0 until commit_tag=5; then mem_wr=1, addr=0x200+imm.
- Fill DEPTH entries → full=1, iss_ready=0; one ack → full=0 next cycle; tail wraps to 0 correctly.
- Two committed SB, one uncommitted SW, two loads queued; flush → count=2; both SB drain; no res_valid.
- Head LB in flight, flush asserted; ack 3 cycles later → res_valid stays 0, queue empty=1 afterwards.
- Issue with j tag 7 while CDB port 0 broadcasts tag 7 same cycle → value captured, entry dispatches without further wakeup.
